// File: rtl/mem_responder_if.sv
// mem_responder_if: command, write-data and read-response
// channels between a requester (master) and mem_responder (slave).
interface mem_responder_if #(
  parameter int ADDR_BITS = 26,
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 128
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [TAG_BITS-1:0]  cmd_tag;
  logic                 cmd_rw;
  logic                 data_valid;
  logic                 data_ready;
  logic [DATA_BITS-1:0] data_data;
  logic                 resp_valid;
  logic [DATA_BITS-1:0] resp_data;
  logic [TAG_BITS-1:0]  resp_tag;

  modport master (
    output cmd_valid,
    output cmd_addr,
    output cmd_tag,
    output cmd_rw,
    output data_valid,
    output data_data,
    input  cmd_ready,
    input  data_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_tag
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_tag,
    input  cmd_rw,
    input  data_valid,
    input  data_data,
    output cmd_ready,
    output data_ready,
    output resp_valid,
    output resp_data,
    output resp_tag
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: line-oriented memory model answering tagged
// multi-beat reads after a fixed latency and absorbing multi-beat writes.
module mem_responder #(
  parameter int ADDR_BITS = 26,
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 128,
  parameter int BEATS     = 4,
  parameter int LINES     = 1024,
  parameter int LATENCY   = 2
) (
  input  logic           clk,
  input  logic           rstn,
  mem_responder_if.slave bus
);
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW = LW + ((BEATS > 1) ? $clog2(BEATS) : 0);
  localparam int DEPTH = LINES * BEATS;
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LWAIT = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(LWAIT);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ_WAIT,
    READ_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [TW-1:0]        lat_q, lat_d;
  logic [LW-1:0]        line_q, line_d;
  logic [TAG_BITS-1:0]  tag_q, tag_d;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [WW-1:0]        widx;
  logic                 data_hs;

  assign widx = WW'(line_q) * WW'(BEATS) + WW'(beat_q);
  assign data_hs = bus.data_valid & bus.data_ready;
  assign bus.resp_data = mem[widx];
  assign bus.resp_tag = tag_q;

  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    lat_d = lat_q;
    line_d = line_q;
    tag_d = tag_q;
    bus.cmd_ready = 1'b0;
    bus.data_ready = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          line_d = bus.cmd_addr[LW-1:0];
          tag_d = bus.cmd_tag;
          beat_d = '0;
          lat_d = '0;
          if (bus.cmd_rw)
            state_d = WRITE;
          else if (LATENCY > 1)
            state_d = READ_WAIT;
          else
            state_d = READ_RESP;
        end
      end
      WRITE: begin
        bus.data_ready = 1'b1;
        if (bus.data_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            state_d = IDLE;
          end
        end
      end
      READ_WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAST_WAIT) begin
          lat_d = '0;
          state_d = READ_RESP;
        end
      end
      READ_RESP: begin
        bus.resp_valid = 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      beat_q <= '0;
      lat_q <= '0;
      line_q <= '0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      lat_q <= lat_d;
      line_q <= line_d;
      tag_q <= tag_d;
    end
  end

  // Storage survives reset; a beat racing reset is dropped.
  always_ff @(posedge clk) begin
    if (rstn && data_hs)
      mem[widx] <= bus.data_data;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random and directed stimulus checked every cycle
// against a cycle-scheduled behavioural model of the responder.
module tb_mem_responder;
  localparam int AB = 26;
  localparam int TGB = 5;
  localparam int DB = 128;
  localparam int BEATS = 4;
  localparam int LINES = 1024;
  localparam int LAT = 2;

  typedef logic [DB-1:0] line_t [BEATS];
  typedef struct {
    logic [DB-1:0]  d;
    logic [TGB-1:0] t;
    bit             k;
  } exp_t;
  typedef struct {
    int             c;
    logic [DB-1:0]  d;
    logic [TGB-1:0] t;
  } cap_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(
    .ADDR_BITS(AB), .TAG_BITS(TGB), .DATA_BITS(DB)
  ) bus ();

  mem_responder #(
    .ADDR_BITS(AB), .TAG_BITS(TGB), .DATA_BITS(DB),
    .BEATS(BEATS), .LINES(LINES), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit armed = 0;
  int wr_left = 0;
  int wr_base = 0;
  int wr_idx = 0;
  int free_cyc = 0;
  exp_t exp_q [int];
  logic [DB-1:0] ref_mem [int];
  cap_t cap [$];

  task automatic chk(input string nm, input logic [DB-1:0] act,
                     input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: a command accepted in cycle c schedules read beats
  // at c+LAT+i and blocks commands until c+LAT+BEATS.
  always @(posedge clk) begin
    int line;
    int w;
    exp_t e;
    int ks [$];
    if (!rstn) begin
      armed = 1;
      wr_left = 0;
      free_cyc = cyc + 1;
      foreach (exp_q[k]) if (k > cyc) ks.push_back(k);
      foreach (ks[j]) exp_q.delete(ks[j]);
    end else if (armed) begin
      if (wr_left == 0 && cyc >= free_cyc && bus.cmd_valid) begin
        line = int'(bus.cmd_addr) % LINES;
        if (bus.cmd_rw) begin
          wr_left = BEATS;
          wr_base = line * BEATS;
          wr_idx = 0;
        end else begin
          for (int i = 0; i < BEATS; i++) begin
            w = line * BEATS + i;
            e.k = ref_mem.exists(w);
            e.d = '0;
            if (e.k) e.d = ref_mem[w];
            e.t = bus.cmd_tag;
            exp_q[cyc + LAT + i] = e;
          end
          free_cyc = cyc + LAT + BEATS;
        end
      end else if (wr_left > 0 && bus.data_valid) begin
        ref_mem[wr_base + wr_idx] = bus.data_data;
        wr_idx++;
        wr_left--;
        if (wr_left == 0) free_cyc = cyc + 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit rv;
    if (armed) begin
      chk("cmd_ready", DB'(bus.cmd_ready),
          DB'(wr_left == 0 && cyc >= free_cyc));
      chk("data_ready", DB'(bus.data_ready), DB'(wr_left != 0));
      rv = exp_q.exists(cyc);
      chk("resp_valid", DB'(bus.resp_valid), DB'(rv));
      if (rv) begin
        chk("resp_tag", DB'(bus.resp_tag), DB'(exp_q[cyc].t));
        if (exp_q[cyc].k)
          chk("resp_data", bus.resp_data, exp_q[cyc].d);
        exp_q.delete(cyc);
      end
    end
  end

  always @(negedge clk) begin
    cap_t c;
    if (bus.resp_valid === 1'b1) begin
      c.c = cyc;
      c.d = bus.resp_data;
      c.t = bus.resp_tag;
      cap.push_back(c);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit rw, input int addr, input int tag,
                          output int hc);
    int n;
    bit done;
    n = 0;
    done = 0;
    hc = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rw = rw;
    bus.cmd_addr = AB'(addr);
    bus.cmd_tag = TGB'(tag);
    while (!done) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin
        done = 1;
        hc = cyc;
      end
      tick();
      n++;
      if (!done && n > 200) begin
        checks++;
        errors++;
        $display("FAIL cmd_timeout cyc=%0d got=no_accept want=accept", cyc);
        done = 1;
      end
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input line_t d, input int gmax);
    int n;
    bit done;
    for (int i = 0; i < BEATS; i++) begin
      bus.data_valid = 1'b0;
      repeat ($urandom_range(gmax, 0)) tick();
      bus.data_valid = 1'b1;
      bus.data_data = d[i];
      n = 0;
      done = 0;
      while (!done) begin
        @(negedge clk);
        if (bus.data_ready === 1'b1) done = 1;
        tick();
        n++;
        if (!done && n > 200) begin
          checks++;
          errors++;
          $display("FAIL beat_timeout cyc=%0d got=no_accept want=accept", cyc);
          done = 1;
        end
      end
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic write_line(input int addr, input line_t d, input int gmax);
    int hc;
    send_cmd(1'b1, addr, 0, hc);
    send_beats(d, gmax);
  endtask

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < BEATS; i++)
      r[i] = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  task automatic chk_line(input string nm, input line_t d, input int tag,
                          input int hc);
    chk({nm, "_count"}, DB'(cap.size()), DB'(BEATS));
    for (int i = 0; i < cap.size() && i < BEATS; i++) begin
      chk({nm, "_data"}, cap[i].d, d[i]);
      chk({nm, "_tag"}, DB'(cap[i].t), DB'(tag));
      chk({nm, "_cyc"}, DB'(cap[i].c - hc), DB'(2 + i));
    end
  endtask

  initial begin
    line_t d3;
    line_t d9;
    line_t d5;
    int hc;
    int h2;
    d3[0] = 128'h11;
    d3[1] = 128'h22;
    d3[2] = 128'h33;
    d3[3] = 128'h44;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_tag = '0;
    bus.cmd_rw = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_data = '0;
    repeat (3) tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", DB'(bus.cmd_ready), DB'(1));
    chk("rst_data_ready", DB'(bus.data_ready), DB'(0));
    chk("rst_resp_valid", DB'(bus.resp_valid), DB'(0));
    tick();

    write_line(3, d3, 0);
    cap.delete();
    send_cmd(1'b0, 3, 7, hc);
    repeat (LAT + BEATS) tick();
    chk_line("basic", d3, 7, hc);

    d9 = rand_line();
    write_line(9, d9, 3);
    send_cmd(1'b0, 9, 11, hc);
    repeat (LAT + BEATS) tick();

    d5 = rand_line();
    write_line(LINES + 5, d5, 1);
    cap.delete();
    send_cmd(1'b0, 5, 3, hc);
    repeat (LAT + BEATS) tick();
    chk_line("alias", d5, 3, hc);

    cap.delete();
    send_cmd(1'b0, 3, 1, hc);
    send_cmd(1'b0, LINES + 5, 2, h2);
    repeat (LAT + BEATS) tick();
    chk("b2b_gap", DB'(h2 - hc), DB'(6));
    chk("b2b_count", DB'(cap.size()), DB'(8));
    for (int i = 0; i < cap.size() && i < 8; i++) begin
      chk("b2b_tag", DB'(cap[i].t), DB'(i < 4 ? 1 : 2));
      chk("b2b_cyc", DB'(cap[i].c - hc), DB'(i < 4 ? 2 + i : 4 + i));
    end

    cap.delete();
    send_cmd(1'b0, 3, 4, hc);
    repeat (LAT) @(posedge clk);
    #1;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("rst_mid_beats", DB'(cap.size()), DB'(2));

    bus.data_valid = 1'b1;
    repeat (6) begin
      bus.data_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    bus.data_valid = 1'b0;
    cap.delete();
    send_cmd(1'b0, 3, 9, hc);
    repeat (LAT + BEATS) tick();
    chk_line("idle_data", d3, 9, hc);

    for (int n = 0; n < 40; n++) begin
      int addr;
      addr = $urandom_range(7, 0) + $urandom_range(3, 0) * LINES;
      if ($urandom_range(3, 0) == 0) begin
        bus.data_valid = 1'b1;
        bus.data_data = {$urandom, $urandom, $urandom, $urandom};
        repeat ($urandom_range(3, 1)) tick();
        bus.data_valid = 1'b0;
      end
      if ($urandom_range(1, 0) == 1)
        write_line(addr, rand_line(), 3);
      else
        send_cmd(1'b0, addr, int'($urandom_range(31, 0)), hc);
    end
    repeat (12) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
